ethclk_supervisor: RTL

Lock supervisor and reset sequencer for the Ethernet recovered-clock PLL. It runs on the free-running local 40 MHz system clock and owns the PLL's reset. It watches the PLL lock, qualifies it, and publishes a debounced "Ethernet clock OK" plus a clock-select for the downstream clock mux. It retries failed locks, falls back to the local clock after repeated failure, and keeps a lock-loss count for slow control.

---
 rtl/ethclk_pkg.sv | 17 +
 rtl/sync_ff2.sv | 28 ++
 rtl/ethclk_supervisor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ethclk_pkg.sv
// ethclk_pkg: shared definitions for the Ethernet recovered-clock supervisor.
//   state_t : FSM state codes, also published on the state output
//   LLC_W   : width of the saturating lock-loss counter
package ethclk_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_HOLD   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam int LLC_W = 8;

endpackage

// File: rtl/sync_ff2.sv
// sync_ff2: generic two-flop synchronizer for level signals crossing into clk.
//   clk  : destination clock
//   rstn : synchronous active-low reset, both stages clear to 0
//   d    : asynchronous input
//   q    : synchronized output, two clk edges after d
module sync_ff2 #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;

  // stage p0 captures the asynchronous level, q re-times it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/ethclk_supervisor.sv
// ethclk_supervisor: lock supervisor and reset sequencer for the Ethernet
// recovered-clock PLL, running entirely on the local 40 MHz clock.
//   clk40           : local system clock
//   rstn            : synchronous active-low reset
//   ethrxclk_locked : PLL LOCKED, asynchronous to clk40
//   force_rst       : one-cycle request, restart from S_RST
//   retry_req       : one-cycle request, leave S_FAIL now
//   lock_loss_clr   : one-cycle request, clear lock_loss_cnt
//   ethrxclk_rst    : PLL reset, active high
//   ethrxclk_ok     : qualified lock, high only in S_RUN
//   clk_sel         : 1 selects the Ethernet clock, 0 the local clock
//   fail            : high in S_FAIL
//   state           : current state code
//   lock_loss_cnt   : saturating count of RUN->HOLD transitions
module ethclk_supervisor
  import ethclk_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 40000,
  parameter int SETTLE_CYCLES  = 4000,
  parameter int HOLDOFF_CYCLES = 400,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_INTERVAL = 4000000,
  parameter int CNT_W          = 24
) (
  input  logic             clk40,
  input  logic             rstn,
  input  logic             ethrxclk_locked,
  input  logic             force_rst,
  input  logic             retry_req,
  input  logic             lock_loss_clr,
  output logic             ethrxclk_rst,
  output logic             ethrxclk_ok,
  output logic             clk_sel,
  output logic             fail,
  output logic [2:0]       state,
  output logic [LLC_W-1:0] lock_loss_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FAIL_LAST   = CNT_W'(RETRY_INTERVAL - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);

  function automatic logic [LLC_W-1:0] sat_inc(input logic [LLC_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic               locked_s;
  state_t             cur;
  state_t             nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_nxt;
  logic               attempt_fail;
  logic               loss;

  sync_ff2 #(
    .DATA_W(1)
  ) u_lock_sync (
    .clk  (clk40),
    .rstn (rstn),
    .d    (ethrxclk_locked),
    .q    (locked_s)
  );

  always_comb begin
    nxt          = cur;
    retry_nxt    = retry;
    attempt_fail = 1'b0;
    loss         = 1'b0;
    if (force_rst) begin
      // Overrides everything, including the lock-loss count in S_RUN.
      nxt       = S_RST;
      retry_nxt = '0;
    end else begin
      case (cur)
        S_RST: begin
          if (cnt == RST_LAST) nxt = S_WAIT;
        end
        S_WAIT: begin
          if (locked_s)               nxt = S_SETTLE;
          else if (cnt == LOCK_LAST) attempt_fail = 1'b1;
        end
        S_SETTLE: begin
          if (!locked_s) begin
            attempt_fail = 1'b1;
          end else if (cnt == SETTLE_LAST) begin
            nxt       = S_RUN;
            retry_nxt = '0;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            nxt  = S_HOLD;
            loss = 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) nxt = S_RST;
        end
        S_FAIL: begin
          if (retry_req || (cnt == FAIL_LAST)) begin
            nxt       = S_RST;
            retry_nxt = '0;
          end
        end
        default: nxt = S_RST;
      endcase
      if (attempt_fail) begin
        retry_nxt = retry + 1'b1;
        nxt       = (retry == RETRY_LAST) ? S_FAIL : S_RST;
      end
    end
  end

  // Outputs are decoded from nxt so they move on the same edge as state.
  always_ff @(posedge clk40) begin
    if (!rstn) begin
      cur           <= S_RST;
      cnt           <= '0;
      retry         <= '0;
      ethrxclk_rst  <= 1'b1;
      ethrxclk_ok   <= 1'b0;
      clk_sel       <= 1'b0;
      fail          <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      cur          <= nxt;
      retry        <= retry_nxt;
      // force_rst in S_RST keeps the state but must still restart the pulse.
      cnt          <= (force_rst || (nxt != cur)) ? '0 : cnt + 1'b1;
      ethrxclk_rst <= (nxt == S_RST);
      ethrxclk_ok  <= (nxt == S_RUN);
      clk_sel      <= (nxt == S_RUN);
      fail         <= (nxt == S_FAIL);
      if (lock_loss_clr)
        lock_loss_cnt <= '0;
      else if (loss)
        lock_loss_cnt <= sat_inc(lock_loss_cnt);
    end
  end

  assign state = cur;

endmodule
